ahb_slave_resp_mux: RTL and testbench

//  Parametrised AHB-Lite slave-to-master response multiplexer for N_SLAVES slaves.

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_default_slave.sv | 56 +++++
 rtl/ahb_slave_resp_mux.sv | 98 +++++++++
 tb/tb_ahb_slave_resp_mux.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes and the
// state encoding of the integrated default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: answers an active transfer with the
// two-cycle AHB ERROR response, and idle/busy transfers with zero-wait OKAY.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic HREADY,
    input  logic dflt_req,
    output logic ds_hready,
    output logic ds_hresp
);

    ds_state_t state_reg;
    ds_state_t state_next;

    // A new unmapped NONSEQ/SEQ is only accepted when the bus is ready.
    logic capture_err;
    assign capture_err = HREADY && dflt_req;

    // State register; reset aborts any ERROR sequence in progress.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= DS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and response outputs; ERR2 may chain straight into ERR1.
    always_comb begin
        state_next = state_reg;
        ds_hready  = 1'b1;
        ds_hresp   = HRESP_OKAY;
        unique case (state_reg)
            DS_IDLE: begin
                if (capture_err) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_hready  = 1'b0;
                ds_hresp   = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp   = HRESP_ERROR;
                state_next = capture_err ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_resp_mux.sv
// AHB-Lite slave-to-master response multiplexer. The slave select is captured
// in the address phase and steers read data, response and ready during the
// data phase. Unmapped accesses are answered by an internal default slave.
module ahb_slave_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_SLAVES   = 4
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [N_SLAVES-1:0]            HSEL,
    input  logic [1:0]                     HTRANS,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [N_SLAVES-1:0]            HRESP_S,
    input  logic [N_SLAVES-1:0]            HREADYOUT_S,
    output logic [DATA_WIDTH-1:0]          HRDATA,
    output logic                           HRESP,
    output logic                           HREADY,
    output logic                           MULTI_SEL
);

    localparam logic [N_SLAVES-1:0] ONE_VEC = {{(N_SLAVES-1){1'b0}}, 1'b1};

    logic [N_SLAVES-1:0]   dsel_reg;
    logic [N_SLAVES-1:0]   dsel_next;
    logic                  multi_sel_reg;
    logic                  multi_sel_next;
    logic [N_SLAVES-1:0]   hsel_lowest;
    logic                  hsel_multi;
    logic                  dflt_req;
    logic                  ds_hready;
    logic                  ds_hresp;
    logic                  data_sel;
    logic [DATA_WIDTH-1:0] rdata_chain [0:N_SLAVES];

    // Priority encode: isolate the lowest set bit; anything left over means
    // the decoder asserted more than one select.
    assign hsel_lowest = HSEL & (~HSEL + ONE_VEC);
    assign hsel_multi  = |(HSEL & (HSEL - ONE_VEC));
    assign dflt_req    = (HSEL == '0) && HTRANS[1];

    // Address-phase capture only when the current data phase completes.
    always_comb begin
        dsel_next      = dsel_reg;
        multi_sel_next = 1'b0;
        if (HREADY) begin
            dsel_next      = hsel_lowest;
            multi_sel_next = hsel_multi;
        end
    end

    // Data-phase select and multi-select pulse registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_reg      <= '0;
            multi_sel_reg <= 1'b0;
        end else begin
            dsel_reg      <= dsel_next;
            multi_sel_reg <= multi_sel_next;
        end
    end

    // AND-OR read-data mux; dsel_reg is one-hot or zero so at most one term
    // contributes.
    assign rdata_chain[0] = '0;
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rdata
        assign rdata_chain[gi+1] = rdata_chain[gi]
                                 | (HRDATA_S[gi*DATA_WIDTH +: DATA_WIDTH]
                                    & {DATA_WIDTH{dsel_reg[gi]}});
    end

    assign data_sel = |dsel_reg;

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .dflt_req  (dflt_req),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp)
    );

    // Data-phase response steering: selected slave, else the default slave.
    always_comb begin
        HRDATA = '0;
        HRESP  = ds_hresp;
        HREADY = ds_hready;
        if (data_sel) begin
            HRDATA = rdata_chain[N_SLAVES];
            HRESP  = |(dsel_reg & HRESP_S);
            HREADY = |(dsel_reg & HREADYOUT_S);
        end
    end

    assign MULTI_SEL = multi_sel_reg;

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// Self-checking bench for ahb_slave_resp_mux: each cycle's expected response
// is queued when the stimulus is driven and compared when sampled.
module tb_ahb_slave_resp_mux;
    import ahb_pkg::*;

    localparam int DW = 32;
    localparam int NS = 4;

    logic           HCLK;
    logic           HRESET;
    logic [NS-1:0]  HSEL;
    logic [1:0]     HTRANS;
    logic [NS*DW-1:0] HRDATA_S;
    logic [NS-1:0]  HRESP_S;
    logic [NS-1:0]  HREADYOUT_S;
    logic [DW-1:0]  HRDATA;
    logic           HRESP;
    logic           HREADY;
    logic           MULTI_SEL;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [34:0] val;   // {hready, hresp, multi_sel, hrdata}
    } exp_t;

    exp_t sb_q[$];

    ahb_slave_resp_mux #(.DATA_WIDTH(DW), .N_SLAVES(NS)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HRESP_S     (HRESP_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HREADY      (HREADY),
        .MULTI_SEL   (MULTI_SEL)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [34:0] observed,
                            input logic [34:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got rdy/resp/multi/data=%h expected %h", tag, observed, expected);
        end else begin
            $display("ok   %s: rdy/resp/multi/data=%h", tag, observed);
        end
    endtask

    // Drive one address-phase/data-phase cycle and queue the response the
    // master should see during that cycle.
    task automatic step(input string tag, input logic [NS-1:0] hsel, input logic [1:0] htrans,
                        input logic [NS-1:0] rdy_s, input logic [NS-1:0] resp_s,
                        input logic exp_rdy, input logic exp_resp, input logic exp_multi,
                        input logic [DW-1:0] exp_data);
        exp_t e;
        exp_t got;
        @(posedge HCLK);
        #1;
        HSEL        = hsel;
        HTRANS      = htrans;
        HREADYOUT_S = rdy_s;
        HRESP_S     = resp_s;
        e.tag = tag;
        e.val = {exp_rdy, exp_resp, exp_multi, exp_data};
        sb_q.push_back(e);
        @(negedge HCLK);
        got = sb_q.pop_front();
        check_eq(got.tag, {HREADY, HRESP, MULTI_SEL, HRDATA}, got.val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET      = 1'b1;
        HSEL        = '0;
        HTRANS      = HTRANS_IDLE;
        HRESP_S     = '0;
        HREADYOUT_S = '1;
        HRDATA_S    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        #1;
        check_eq("reset_hold", {HREADY, HRESP, MULTI_SEL, HRDATA}, {1'b1, 1'b0, 1'b0, 32'h0});
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;

        // 1: no traffic after reset release
        step("idle_after_reset", 4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        // 2: slave 2 stalls two cycles; an HSEL change during the stall is ignored
        step("s2_addr",   4'b0100, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("s2_wait1",  4'b0000, HTRANS_IDLE,   4'b1011, 4'b0000, 0, 0, 0, 32'hCAFE_0002);
        step("s2_wait2",  4'b0001, HTRANS_NONSEQ, 4'b1011, 4'b0000, 0, 0, 0, 32'hCAFE_0002);
        step("s2_done",   4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'hCAFE_0002);
        step("s2_after",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        // 3: single unmapped NONSEQ, then unmapped IDLE gets zero-wait OKAY
        step("unm_addr",  4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("unm_err1",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 0, 1, 0, 32'h0);
        step("unm_err2",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 1, 0, 32'h0);
        step("unm_okay",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("unm_idle",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("unm_idle2", 4'b0000, HTRANS_BUSY,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("unm_idle3", 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        // 4: back-to-back unmapped, second captured in ERR2
        step("b2b_addr",  4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("b2b_err1a", 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 0, 1, 0, 32'h0);
        step("b2b_err2a", 4'b0000, HTRANS_SEQ,    4'b1111, 4'b0000, 1, 1, 0, 32'h0);
        step("b2b_err1b", 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 0, 1, 0, 32'h0);
        step("b2b_err2b", 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 1, 0, 32'h0);
        step("b2b_idle",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        // 5: non-one-hot select routes the lowest slave and pulses MULTI_SEL
        step("multi_addr", 4'b1010, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("multi_data", 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 1, 32'hCAFE_0001);
        step("multi_clr",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        // slave ERROR passes through unmodified
        step("serr_addr", 4'b0001, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("serr_1",    4'b0000, HTRANS_IDLE,   4'b1110, 4'b0001, 0, 1, 0, 32'hCAFE_0000);
        step("serr_2",    4'b0000, HTRANS_IDLE,   4'b1111, 4'b0001, 1, 1, 0, 32'hCAFE_0000);
        step("serr_done", 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        // 6: asynchronous reset during ERR1
        step("rst_addr",  4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("rst_err1",  4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 0, 1, 0, 32'h0);
        #2;
        HRESET = 1'b1;
        #1;
        check_eq("rst_async", {HREADY, HRESP, MULTI_SEL, HRDATA}, {1'b1, 1'b0, 1'b0, 32'h0});
        @(posedge HCLK);
        #3;
        HRESET = 1'b0;
        step("rst_after",  4'b0000, HTRANS_IDLE,  4'b1111, 4'b0000, 1, 0, 0, 32'h0);
        step("rst_after2", 4'b0000, HTRANS_IDLE,  4'b1111, 4'b0000, 1, 0, 0, 32'h0);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
